// File: rtl/health_pkg.sv
// Shared types and default constants for the fighter health manager.
package health_pkg;

  typedef enum logic [1:0] {
    ALIVE  = 2'd0,
    INVULN = 2'd1,
    DEAD   = 2'd2
  } fighter_state_t;

  localparam int DEF_NUM_FIGHTERS  = 2;
  localparam int DEF_HEALTH_W      = 8;
  localparam int DEF_MAX_HEALTH    = 20;
  localparam int DEF_IFRAME_CYCLES = 32;

endpackage

// File: rtl/fighter_health.sv
// One fighter: hit edge detect, saturating damage, invulnerability window and
// ALIVE/INVULN/DEAD state machine.
module fighter_health
  import health_pkg::*;
#(
  parameter int HEALTH_W      = DEF_HEALTH_W,
  parameter int MAX_HEALTH    = DEF_MAX_HEALTH,
  parameter int IFRAME_CYCLES = DEF_IFRAME_CYCLES
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                round_start_i,
  input  logic                hit_i,
  input  logic [HEALTH_W-1:0] damage_i,
  output logic [HEALTH_W-1:0] health_o,
  output logic                dead_o,
  output logic                invuln_o,
  output logic                hit_ack_o
);

  localparam int                CNT_W    = $clog2(IFRAME_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(IFRAME_CYCLES - 1);
  localparam logic [HEALTH_W-1:0] FULL   = HEALTH_W'(MAX_HEALTH);

  fighter_state_t      state_q, state_d;
  logic [HEALTH_W-1:0] health_q, health_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                hit_prev_q;
  logic                hit_ack_q, hit_ack_d;
  logic                hit_edge;
  logic [HEALTH_W-1:0] health_sub;

  assign hit_edge   = hit_i & ~hit_prev_q;
  assign health_sub = (damage_i >= health_q) ? '0 : health_q - damage_i;

  // NOTE: every always_comb output is given a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    health_d  = health_q;
    cnt_d     = cnt_q;
    hit_ack_d = 1'b0;
    if (round_start_i) begin
      state_d  = ALIVE;
      health_d = FULL;
      cnt_d    = '0;
    end else begin
      unique case (state_q)
        ALIVE: begin
          if (hit_edge) begin
            hit_ack_d = 1'b1;
            health_d  = health_sub;
            if (health_sub == '0) begin
              state_d = DEAD;
            end else begin
              state_d = INVULN;
              cnt_d   = CNT_LOAD;
            end
          end
        end
        // Counter holds the remaining INVULN cycles minus one.
        INVULN: begin
          if (cnt_q == '0) state_d = ALIVE;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        DEAD:    state_d = DEAD;
        default: state_d = ALIVE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= ALIVE;
      health_q   <= FULL;
      cnt_q      <= '0;
      hit_ack_q  <= 1'b0;
      // Ones here stop a Hit held through reset release from looking like an edge.
      hit_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      health_q   <= health_d;
      cnt_q      <= cnt_d;
      hit_ack_q  <= hit_ack_d;
      hit_prev_q <= hit_i;
    end
  end

  assign health_o  = health_q;
  assign dead_o    = (state_q == DEAD);
  assign invuln_o  = (state_q == INVULN);
  assign hit_ack_o = hit_ack_q;

endmodule

// File: rtl/health_manager.sv
// Array of independent fighter health channels plus round outcome decode
// (GameOver / Winner / Draw) taken straight from the registered states.
module health_manager
  import health_pkg::*;
#(
  parameter int NUM_FIGHTERS  = DEF_NUM_FIGHTERS,
  parameter int HEALTH_W      = DEF_HEALTH_W,
  parameter int MAX_HEALTH    = DEF_MAX_HEALTH,
  parameter int IFRAME_CYCLES = DEF_IFRAME_CYCLES
) (
  input  logic                                   Clk,
  input  logic                                   Reset,
  input  logic                                   RoundStart,
  input  logic [NUM_FIGHTERS-1:0]                Hit,
  input  logic [NUM_FIGHTERS-1:0][HEALTH_W-1:0]  Damage,
  output logic [NUM_FIGHTERS-1:0][HEALTH_W-1:0]  Health,
  output logic [NUM_FIGHTERS-1:0]                Death,
  output logic [NUM_FIGHTERS-1:0]                Invuln,
  output logic [NUM_FIGHTERS-1:0]                HitAck,
  output logic                                   GameOver,
  output logic [$clog2(NUM_FIGHTERS)-1:0]        Winner,
  output logic                                   Draw
);

  localparam int WIN_W = $clog2(NUM_FIGHTERS);
  localparam int CNT_W = $clog2(NUM_FIGHTERS + 1);

  if ((MAX_HEALTH >> HEALTH_W) != 0 || IFRAME_CYCLES < 1 || NUM_FIGHTERS < 2) begin : g_bad_params
    $error("health_manager: illegal parameter set");
  end

  for (genvar g = 0; g < NUM_FIGHTERS; g++) begin : g_fighter
    fighter_health #(
      .HEALTH_W      (HEALTH_W),
      .MAX_HEALTH    (MAX_HEALTH),
      .IFRAME_CYCLES (IFRAME_CYCLES)
    ) u_fighter (
      .Clk           (Clk),
      .Reset         (Reset),
      .round_start_i (RoundStart),
      .hit_i         (Hit[g]),
      .damage_i      (Damage[g]),
      .health_o      (Health[g]),
      .dead_o        (Death[g]),
      .invuln_o      (Invuln[g]),
      .hit_ack_o     (HitAck[g])
    );
  end

  logic [CNT_W-1:0] alive_cnt;
  logic [WIN_W-1:0] winner_idx;
  logic             found;

  always_comb begin
    alive_cnt  = '0;
    winner_idx = '0;
    found      = 1'b0;
    for (int i = 0; i < NUM_FIGHTERS; i++) begin
      if (!Death[i]) begin
        alive_cnt = alive_cnt + CNT_W'(1);
        if (!found) begin
          winner_idx = WIN_W'(i);
          found      = 1'b1;
        end
      end
    end
  end

  assign GameOver = (alive_cnt <= CNT_W'(1));
  assign Draw     = (alive_cnt == '0);
  assign Winner   = winner_idx;

endmodule

// File: tb/tb_health_manager.sv
// Self-checking bench: directed scenarios plus random hits, compared every
// cycle against a behavioural per-fighter model.
module tb_health_manager;

  localparam int N    = 2;
  localparam int W    = 8;
  localparam int MAXH = 20;
  localparam int IFR  = 32;

  logic                 Clk = 1'b0;
  logic                 Reset;
  logic                 RoundStart;
  logic [N-1:0]         Hit;
  logic [N-1:0][W-1:0]  Damage;
  logic [N-1:0][W-1:0]  Health;
  logic [N-1:0]         Death;
  logic [N-1:0]         Invuln;
  logic [N-1:0]         HitAck;
  logic                 GameOver;
  logic [$clog2(N)-1:0] Winner;
  logic                 Draw;

  health_manager #(
    .NUM_FIGHTERS (N), .HEALTH_W (W), .MAX_HEALTH (MAXH), .IFRAME_CYCLES (IFR)
  ) dut (
    .Clk (Clk), .Reset (Reset), .RoundStart (RoundStart), .Hit (Hit),
    .Damage (Damage), .Health (Health), .Death (Death), .Invuln (Invuln),
    .HitAck (HitAck), .GameOver (GameOver), .Winner (Winner), .Draw (Draw)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: remaining invulnerable cycles, death flag, last seen Hit level.
  int m_health[N];
  int m_inv_left[N];
  bit m_dead[N];
  bit m_ack[N];
  bit m_prev[N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_health[i]   = MAXH;
      m_inv_left[i] = 0;
      m_dead[i]     = 1'b0;
      m_ack[i]      = 1'b0;
      m_prev[i]     = 1'b1;
    end
  endtask

  task automatic model_clock();
    for (int i = 0; i < N; i++) begin
      bit rising;
      rising    = Hit[i] && !m_prev[i];
      m_prev[i] = Hit[i];
      m_ack[i]  = 1'b0;
      if (RoundStart) begin
        m_health[i]   = MAXH;
        m_inv_left[i] = 0;
        m_dead[i]     = 1'b0;
      end else if (m_dead[i]) begin
        // stays dead
      end else if (m_inv_left[i] > 0) begin
        m_inv_left[i]--;
      end else if (rising) begin
        m_ack[i]    = 1'b1;
        m_health[i] = (int'(Damage[i]) >= m_health[i]) ? 0 : m_health[i] - int'(Damage[i]);
        if (m_health[i] == 0) m_dead[i] = 1'b1;
        else                  m_inv_left[i] = IFR;
      end
    end
  endtask

  task automatic compare_all();
    int alive;
    int win;
    alive = 0;
    win   = -1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("health[%0d]", i), Health[i], m_health[i]);
      check($sformatf("death[%0d]", i),  Death[i],  m_dead[i]);
      check($sformatf("invuln[%0d]", i), Invuln[i], m_inv_left[i] > 0);
      check($sformatf("hitack[%0d]", i), HitAck[i], m_ack[i]);
      if (!m_dead[i]) begin
        alive++;
        if (win < 0) win = i;
      end
    end
    check("gameover", GameOver, alive <= 1);
    check("winner",   Winner,   (win < 0) ? 0 : win);
    check("draw",     Draw,     alive == 0);
  endtask

  task automatic step();
    @(posedge Clk);
    if (Reset) model_reset();
    else       model_clock();
    #1;
    compare_all();
  endtask

  task automatic pulse(input int f, input int dmg);
    Hit[f]    = 1'b1;
    Damage[f] = W'(dmg);
    step();
    Hit[f] = 1'b0;
    step();
  endtask

  task automatic do_reset();
    Reset      = 1'b1;
    RoundStart = 1'b0;
    Hit        = '0;
    Damage     = '0;
    step();
    step();
    Reset = 1'b0;
    step();
  endtask

  int inv_cycles;
  int acks;

  initial begin
    Reset      = 1'b1;
    RoundStart = 1'b0;
    Hit        = '0;
    Damage     = '0;
    model_reset();
    #1;
    check("async_reset_health0", Health[0], MAXH);
    check("async_reset_death", Death, 0);
    do_reset();

    // Single-cycle hit on fighter 1: health 16, one ack, 32 invulnerable cycles.
    Hit[1]    = 1'b1;
    Damage[1] = 8'd4;
    step();
    check("r35_health1", Health[1], 16);
    check("r35_ack1", HitAck[1], 1);
    check("r35_health0", Health[0], 20);
    Hit[1]     = 1'b0;
    inv_cycles = int'(Invuln[1]);
    acks       = 0;
    repeat (40) begin
      step();
      inv_cycles += int'(Invuln[1]);
      acks       += int'(HitAck[1]);
    end
    check("r35_invuln_len", inv_cycles, IFR);
    check("r35_extra_acks", acks, 0);

    // Hit held high for 100 cycles counts once.
    do_reset();
    Hit[0]    = 1'b1;
    Damage[0] = 8'd4;
    acks      = 0;
    repeat (100) begin
      step();
      acks += int'(HitAck[0]);
    end
    check("r36_acks", acks, 1);
    check("r36_health0", Health[0], 16);
    Hit[0] = 1'b0;
    step();

    // Edge during INVULN ignored; edge after INVULN accepted.
    do_reset();
    pulse(0, 4);
    repeat (7) step();
    pulse(0, 4);
    check("r37_ignored", Health[0], 16);
    repeat (40) step();
    pulse(0, 4);
    check("r37_accepted", Health[0], 12);

    // Saturating kill: 3 - 4 -> 0, DEAD, fighter 1 wins.
    do_reset();
    pulse(0, 17);
    check("r38_health3", Health[0], 3);
    repeat (40) step();
    pulse(0, 4);
    check("r38_health0", Health[0], 0);
    check("r38_death0", Death[0], 1);
    check("r38_invuln0", Invuln[0], 0);
    check("r38_gameover", GameOver, 1);
    check("r38_winner", Winner, 1);
    check("r38_draw", Draw, 0);
    pulse(0, 4);
    check("r38_dead_stays", Death[0], 1);

    // Both dead, then RoundStart overriding simultaneous hit edges.
    pulse(1, 25);
    check("r39_draw", Draw, 1);
    check("r39_winner_none", Winner, 0);
    RoundStart = 1'b1;
    Hit        = '1;
    Damage[0]  = 8'd5;
    Damage[1]  = 8'd5;
    step();
    check("r39_health0", Health[0], 20);
    check("r39_health1", Health[1], 20);
    check("r39_noack", HitAck, 0);
    check("r39_gameover", GameOver, 0);
    RoundStart = 1'b0;
    Hit        = '0;
    step();

    // Asynchronous reset mid-cycle during INVULN, Hit held across release.
    do_reset();
    pulse(0, 12);
    check("r40_health8", Health[0], 8);
    check("r40_invuln", Invuln[0], 1);
    Hit[0] = 1'b1;
    step();
    #2 Reset = 1'b1;
    #1;
    check("r40_async_health", Health[0], 20);
    check("r40_async_invuln", Invuln[0], 0);
    model_reset();
    step();
    Reset = 1'b0;
    step();
    check("r40_no_hit_ack", HitAck[0], 0);
    check("r40_no_hit_health", Health[0], 20);
    Hit[0] = 1'b0;
    step();

    // Random traffic against the model.
    repeat (3000) begin
      for (int i = 0; i < N; i++) begin
        Hit[i]    = ($urandom_range(0, 2) == 0);
        Damage[i] = W'($urandom_range(0, 9));
      end
      RoundStart = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/health_manager.md
HEALTH_MANAGER -- requirements
Module: health_manager

Interface
REQ-001 SHALL have parameter NUM_FIGHTERS, 2, number of independent health channels (>=2).
REQ-002 SHALL have parameter HEALTH_W, 8, width of each health value and damage value.
REQ-003 SHALL have parameter MAX_HEALTH, 20, full health loaded at reset and round start (< 2**HEALTH_W).
REQ-004 SHALL have parameter IFRAME_CYCLES, 32, invulnerability length after an accepted hit (>=1).
REQ-005 SHALL have port Clk  input  1  sole clock, all state on its rising edge.
REQ-006 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port RoundStart  input  1  synchronous restore of all fighters.
REQ-008 SHALL have port Hit  input  [NUM_FIGHTERS]  level hit strobe per fighter; only rising edges count.
REQ-009 SHALL have port Damage  input  [NUM_FIGHTERS][HEALTH_W]  damage applied with that fighter's hit.
REQ-010 SHALL have port Health  output  [NUM_FIGHTERS][HEALTH_W]  registered current health.
REQ-011 SHALL have port Death  output  [NUM_FIGHTERS]  high while fighter is DEAD.
REQ-012 SHALL have port Invuln  output  [NUM_FIGHTERS]  high while fighter is INVULN.
REQ-013 SHALL have port HitAck  output  [NUM_FIGHTERS]  one-cycle pulse per accepted hit.
REQ-014 SHALL have port GameOver  output  1  high when at most one fighter is not DEAD.
REQ-015 SHALL have port Winner  output  $clog2(NUM_FIGHTERS)  lowest-index non-DEAD fighter, 0 when none.
REQ-016 SHALL have port Draw  output  1  high when all fighters are DEAD.

Function
REQ-017 Each fighter SHALL run FSM ALIVE, INVULN, DEAD.
REQ-018 Hit edge SHALL be Hit[i]=1 this cycle and registered previous Hit[i]=0; edge-detect register updates every cycle.
REQ-019 Edge in ALIVE SHALL be accepted: Health[i] <= Health[i] - Damage[i], saturating at 0; HitAck[i] high the following cycle; 1-cycle latency edge to Health.
REQ-020 Accepted hit with post-subtraction health > 0 SHALL go ALIVE->INVULN and hold INVULN exactly IFRAME_CYCLES cycles, then ALIVE.
REQ-021 Accepted hit with post-subtraction health = 0 SHALL go directly to DEAD; Invuln stays 0.
REQ-022 Damage=0 hit SHALL be accepted (HitAck, INVULN entered), health unchanged.
REQ-023 Edges in INVULN or DEAD SHALL be discarded, not queued; no HitAck.
REQ-024 Hit held high SHALL count as one hit only.
REQ-025 RoundStart SHALL, next cycle, set every Health to MAX_HEALTH, state ALIVE, clear INVULN counter; it overrides same-cycle hits (no HitAck); edge-detect register unaffected.
REQ-026 DEAD SHALL exit only via RoundStart or Reset.
REQ-027 GameOver, Winner, Draw SHALL be combinational from registered states, no extra latency.
REQ-028 Fighters SHALL be fully independent; simultaneous hits on different fighters all apply in the same cycle.

Reset
REQ-029 Reset SHALL asynchronously force Health=MAX_HEALTH, state ALIVE, Invuln=0, Death=0, HitAck=0, INVULN counters=0.
REQ-030 Edge-detect registers SHALL reset to all ones so a Hit held through reset release is not a hit.
REQ-031 Reset mid-INVULN or while DEAD SHALL take effect immediately, no cycle alignment.

Structure
REQ-032 Shared package health_pkg SHALL hold fighter_state_t enum (ALIVE, INVULN, DEAD) and default parameter constants.
REQ-033 Per-fighter logic SHALL be sub-module fighter_health (FSM, edge detect, saturating subtract, INVULN counter), instantiated NUM_FIGHTERS times by generate; health_manager adds only GameOver/Winner/Draw.
REQ-034 Elaboration SHALL fail if MAX_HEALTH >= 2**HEALTH_W, IFRAME_CYCLES < 1 or NUM_FIGHTERS < 2.

Verification (defaults)
REQ-035 Reset, 1-cycle Hit[1] with Damage[1]=4 -> next cycle Health[1]=16, HitAck[1] one cycle, Invuln[1] high exactly 32 cycles; Health[0]=20.
REQ-036 Hit[0] held 100 cycles, Damage=4 -> Health[0]=16 only, single HitAck pulse.
REQ-037 After hit to 16, second edge at INVULN cycle 10 -> ignored; edge after INVULN ends -> Health=12.
REQ-038 Health[0]=3, Damage[0]=4 -> Health[0]=0, Death[0]=1, Invuln[0]=0, GameOver=1, Winner=1, Draw=0; further edges ignored.
REQ-039 Both DEAD, then RoundStart with simultaneous Hit edges on both -> both Health=20, ALIVE, no HitAck, GameOver=0.
REQ-040 Reset asserted mid-clock during INVULN with Health=8 -> Health=20, Invuln=0 before next Clk edge; Hit held across release -> no hit.
